ps2_scan_rx: RTL and testbench

PS/2 keyboard receiver directly upstream of the game state machine's keyboard handler. It samples the raw PS/2 clock/data pins, deframes 11-bit device-to-host frames, and folds E0 (extended) and F0 (break) prefixes into flags. It delivers one qualified scan code per keystroke event, with a single-cycle valid strobe, in the system Clk domain.

---
 rtl/ps2_scan_rx_if.sv | 21 ++
 rtl/ps2_scan_rx.sv | 204 ++++++++++++++++++++
 tb/tb_ps2_scan_rx.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_rx_if.sv
// Keyboard-side pins and scan-code delivery signals of ps2_scan_rx.
// The receiver uses the slave modport; the keyboard/consumer side uses master.
interface ps2_scan_rx_if;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;

    modport master (
        output PS2_CLK, PS2_DATA,
        input  scan_code, code_valid, is_break, is_extended, frame_err
    );

    modport slave (
        input  PS2_CLK, PS2_DATA,
        output scan_code, code_valid, is_break, is_extended, frame_err
    );
endinterface

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin conditioning, 11-bit frame deframing, E0/F0 prefix folding.
// Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat make codes of the currently held key.
module ps2_scan_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic         Clk,
    input  logic         Reset,
    ps2_scan_rx_if.slave ps2
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    state_e         state_q, state_d;
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, filt_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           fall_q, fall_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic [TCW-1:0] tcnt_q, tcnt_d;
    logic           ext_pend_q, ext_pend_d;
    logic           brk_pend_q, brk_pend_d;
    logic [7:0]     scan_code_q, scan_code_d;
    logic           is_break_q, is_break_d;
    logic           is_extended_q, is_extended_d;
    logic           code_valid_q, code_valid_d;
    logic           frame_err_q, frame_err_d;
    logic           frame_ok;
    logic           deliver;
`ifdef PS2_TYPEMATIC_FILTER_EN
    logic           held_v_q, held_v_d;
    logic [8:0]     held_q, held_d;
    logic           held_match;
`endif

    // Stop bit must be 1 and data plus parity must carry an odd number of ones.
    assign frame_ok = dat_s2_q & (^{shift_q, parity_q});

    // The filtered clock only follows the pin once it has held a new level for FILTER_LEN samples.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
            else                                fcnt_d = fcnt_q + FCW'(1);
        end
        fall_d = filt_q & ~filt_d;
    end

`ifdef PS2_TYPEMATIC_FILTER_EN
    assign held_match = held_v_q && (held_q == {ext_pend_q, shift_q});
`endif

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        parity_d      = parity_q;
        tcnt_d        = tcnt_q;
        ext_pend_d    = ext_pend_q;
        brk_pend_d    = brk_pend_q;
        scan_code_d   = scan_code_q;
        is_break_d    = is_break_q;
        is_extended_d = is_extended_q;
        code_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        deliver       = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        held_v_d      = held_v_q;
        held_d        = held_q;
`endif
        if (fall_q) begin
            tcnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    parity_d = dat_s2_q;
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        deliver = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
                        // Make of the held key is an auto-repeat; break of the held key releases it.
                        if (!brk_pend_q) begin
                            if (held_match) begin
                                deliver = 1'b0;
                            end else begin
                                held_v_d = 1'b1;
                                held_d   = {ext_pend_q, shift_q};
                            end
                        end else if (held_match) begin
                            held_v_d = 1'b0;
                        end
`endif
                        if (deliver) begin
                            code_valid_d  = 1'b1;
                            scan_code_d   = shift_q;
                            is_break_d    = brk_pend_q;
                            is_extended_d = ext_pend_q;
                        end
                        ext_pend_d = 1'b0;
                        brk_pend_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
                state_d    = S_IDLE;
                tcnt_d     = '0;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end else begin
                tcnt_d = tcnt_q + TCW'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        // NOTE: reset values put the synchronizers and filter at the idle-high line level so
        // releasing reset cannot manufacture a falling edge.
        if (!Reset) begin
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            fcnt_q        <= '0;
            fall_q        <= 1'b0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            parity_q      <= 1'b0;
            tcnt_q        <= '0;
            ext_pend_q    <= 1'b0;
            brk_pend_q    <= 1'b0;
            scan_code_q   <= '0;
            is_break_q    <= 1'b0;
            is_extended_q <= 1'b0;
            code_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_v_q      <= 1'b0;
            held_q        <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            clk_s1_q      <= ps2.PS2_CLK;
            clk_s2_q      <= clk_s1_q;
            dat_s1_q      <= ps2.PS2_DATA;
            dat_s2_q      <= dat_s1_q;
            filt_q        <= filt_d;
            fcnt_q        <= fcnt_d;
            fall_q        <= fall_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            parity_q      <= parity_d;
            tcnt_q        <= tcnt_d;
            ext_pend_q    <= ext_pend_d;
            brk_pend_q    <= brk_pend_d;
            scan_code_q   <= scan_code_d;
            is_break_q    <= is_break_d;
            is_extended_q <= is_extended_d;
            code_valid_q  <= code_valid_d;
            frame_err_q   <= frame_err_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held_v_q      <= held_v_d;
            held_q        <= held_d;
`endif
        end
    end

    assign ps2.scan_code   = scan_code_q;
    assign ps2.code_valid  = code_valid_q;
    assign ps2.is_break    = is_break_q;
    assign ps2.is_extended = is_extended_q;
    assign ps2.frame_err   = frame_err_q;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// Self-checking bench for ps2_scan_rx: directed scenarios plus randomized frames against a
// behavioural scan-code model. Works with or without PS2_TYPEMATIC_FILTER_EN.
module tb_ps2_scan_rx;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 30;
    // Two synchronizer stages, FILTER_LEN samples, the fall pulse, then the registered strobe.
    localparam int LAT            = FILTER_LEN + 3;

    typedef struct packed {
        logic [7:0] code;
        logic       brk;
        logic       ext;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    ps2_scan_rx_if ps2();

    ps2_scan_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .ps2   (ps2)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record every strobe and count protocol anomalies.
    ev_t got_q[$];
    int  err_cnt = 0, mon_bad = 0, last_valid_cyc = 0, last_err_cyc = 0, stop_fall_cyc = 0;
    bit  prev_valid = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        if (ps2.code_valid) begin
            got_q.push_back({ps2.scan_code, ps2.is_break, ps2.is_extended});
            last_valid_cyc = cyc;
        end
        if (ps2.frame_err) begin
            err_cnt++;
            last_err_cyc = cyc;
        end
        if ((ps2.code_valid && ps2.frame_err) || (ps2.code_valid && prev_valid) ||
            (ps2.frame_err && prev_err))
            mon_bad++;
        prev_valid = ps2.code_valid;
        prev_err   = ps2.frame_err;
    end

    // Behavioural model of the keystroke stream.
    ev_t        exp_q[$];
    int         exp_err;
    bit         m_ext, m_brk, m_held_v;
    logic [8:0] m_held;
    logic [7:0] pool [4] = '{8'h1C, 8'h23, 8'h29, 8'h75};

    task automatic model_frame(input logic [7:0] b, input bit ok);
        bit keep;
        if (!ok) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            keep = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!m_brk && m_held_v && m_held == {m_ext, b}) keep = 1'b0;
            else if (!m_brk) begin m_held_v = 1'b1; m_held = {m_ext, b}; end
            else if (m_held_v && m_held == {m_ext, b}) m_held_v = 1'b0;
`endif
            if (keep) exp_q.push_back({b, m_brk, m_ext});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first nbits of an 11-bit frame; a 3-cycle low glitch is placed in the high
    // phase of bit glitch_at (negative for none).
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half, input int glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2.PS2_DATA = bits[i];
            if (i == glitch_at) begin
                wait_cyc(12);
                ps2.PS2_CLK = 1'b0;
                wait_cyc(3);
                ps2.PS2_CLK = 1'b1;
                wait_cyc(half - 15);
            end else begin
                wait_cyc(half);
            end
            ps2.PS2_CLK = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            wait_cyc(half);
            ps2.PS2_CLK = 1'b1;
        end
        ps2.PS2_DATA = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_at, input int half);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        send_bits(bits, 11, half, glitch_at);
        wait_cyc(20);
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        ps2.PS2_CLK  = 1'b1;
        ps2.PS2_DATA = 1'b1;
        wait_cyc(4);
        rst_n = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        ps2.PS2_CLK  = 1'b1;
        ps2.PS2_DATA = 1'b1;
        wait_cyc(5);
        n_total++;
        if (ps2.scan_code !== 8'h00) $display("FAIL reset_scan_code got=%h exp=00", ps2.scan_code);
        else n_pass++;
        n_total++;
        if ({ps2.code_valid, ps2.is_break, ps2.is_extended, ps2.frame_err} !== 4'b0)
            $display("FAIL reset_flags got=%b exp=0000",
                     {ps2.code_valid, ps2.is_break, ps2.is_extended, ps2.frame_err});
        else n_pass++;
        rst_n = 1'b1;
        wait_cyc(20);
    endtask

    task automatic test_basic();
        int g0, e0, b0;
        ev_t ev;
        do_reset();
        g0 = got_q.size(); e0 = err_cnt; b0 = mon_bad;
        send_frame(8'h1D, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0) ? got_q[g0] : '1;
        n_total++;
        if (got_q.size() - g0 !== 1) $display("FAIL basic_count got=%0d exp=1", got_q.size() - g0);
        else n_pass++;
        n_total++;
        if (ev !== {8'h1D, 1'b0, 1'b0}) $display("FAIL basic_event got=%h exp=%h", ev, {8'h1D, 2'b00});
        else n_pass++;
        n_total++;
        if (last_valid_cyc - stop_fall_cyc !== LAT)
            $display("FAIL basic_latency got=%0d exp=%0d", last_valid_cyc - stop_fall_cyc, LAT);
        else n_pass++;
        n_total++;
        if (err_cnt - e0 !== 0 || mon_bad - b0 !== 0)
            $display("FAIL basic_errs got=%0d/%0d exp=0/0", err_cnt - e0, mon_bad - b0);
        else n_pass++;
        n_total++;
        if (ps2.scan_code !== 8'h1D || ps2.code_valid !== 1'b0)
            $display("FAIL basic_hold got=%h/%b exp=1d/0", ps2.scan_code, ps2.code_valid);
        else n_pass++;
    endtask

    task automatic test_prefix();
        int g0;
        ev_t ev;
        do_reset();
        g0 = got_q.size();
        send_frame(8'hE0, 1'b0, 1'b0, -1, HALF);
        send_frame(8'hF0, 1'b0, 1'b0, -1, HALF);
        n_total++;
        if (got_q.size() - g0 !== 0) $display("FAIL prefix_no_strobe got=%0d exp=0", got_q.size() - g0);
        else n_pass++;
        send_frame(8'h75, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0) ? got_q[g0] : '1;
        n_total++;
        if (got_q.size() - g0 !== 1 || ev !== {8'h75, 1'b1, 1'b1})
            $display("FAIL prefix_ext_break got=%h n=%0d exp=%h n=1", ev, got_q.size() - g0, {8'h75, 2'b11});
        else n_pass++;
        send_frame(8'h1D, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0 + 1) ? got_q[g0 + 1] : '1;
        n_total++;
        if (got_q.size() - g0 !== 2 || ev !== {8'h1D, 1'b0, 1'b0})
            $display("FAIL prefix_cleared got=%h n=%0d exp=%h n=2", ev, got_q.size() - g0, {8'h1D, 2'b00});
        else n_pass++;
        n_total++;
        if (ps2.is_break !== 1'b0 || ps2.is_extended !== 1'b0)
            $display("FAIL prefix_flags got=%b%b exp=00", ps2.is_break, ps2.is_extended);
        else n_pass++;
    endtask

    task automatic test_frame_errors();
        int g0, e0;
        ev_t ev;
        do_reset();
        g0 = got_q.size(); e0 = err_cnt;
        send_frame(8'h1D, 1'b1, 1'b0, -1, HALF);
        n_total++;
        if (err_cnt - e0 !== 1 || got_q.size() - g0 !== 0)
            $display("FAIL err_parity got=err%0d/valid%0d exp=err1/valid0", err_cnt - e0, got_q.size() - g0);
        else n_pass++;
        n_total++;
        if (last_err_cyc - stop_fall_cyc !== LAT)
            $display("FAIL err_latency got=%0d exp=%0d", last_err_cyc - stop_fall_cyc, LAT);
        else n_pass++;
        send_frame(8'h1D, 1'b0, 1'b1, -1, HALF);
        n_total++;
        if (err_cnt - e0 !== 2 || got_q.size() - g0 !== 0)
            $display("FAIL err_stop got=err%0d/valid%0d exp=err2/valid0", err_cnt - e0, got_q.size() - g0);
        else n_pass++;
        send_frame(8'hF0, 1'b0, 1'b0, -1, HALF);
        send_frame(8'h1C, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0) ? got_q[g0] : '1;
        n_total++;
        if (got_q.size() - g0 !== 1 || ev !== {8'h1C, 1'b1, 1'b0})
            $display("FAIL err_recover got=%h n=%0d exp=%h n=1", ev, got_q.size() - g0, {8'h1C, 2'b10});
        else n_pass++;
        n_total++;
        if (err_cnt - e0 !== 2) $display("FAIL err_total got=%0d exp=2", err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int g0, e0;
        ev_t ev;
        do_reset();
        g0 = got_q.size(); e0 = err_cnt;
        send_bits({2'b11, 8'h29, 1'b0}, 5, HALF, -1);
        wait_cyc(TIMEOUT_CYCLES + 50);
        n_total++;
        if (got_q.size() - g0 !== 0 || err_cnt - e0 !== 0)
            $display("FAIL timeout_silent got=valid%0d/err%0d exp=0/0", got_q.size() - g0, err_cnt - e0);
        else n_pass++;
        send_frame(8'h29, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0) ? got_q[g0] : '1;
        n_total++;
        if (got_q.size() - g0 !== 1 || ev !== {8'h29, 1'b0, 1'b0})
            $display("FAIL timeout_next got=%h n=%0d exp=%h n=1", ev, got_q.size() - g0, {8'h29, 2'b00});
        else n_pass++;
        n_total++;
        if (err_cnt - e0 !== 0) $display("FAIL timeout_err got=%0d exp=0", err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int g0, e0;
        ev_t ev0, ev1;
        do_reset();
        g0 = got_q.size(); e0 = err_cnt;
        ps2.PS2_DATA = 1'b0;
        ps2.PS2_CLK  = 1'b0;
        wait_cyc(3);
        ps2.PS2_CLK  = 1'b1;
        wait_cyc(30);
        ps2.PS2_DATA = 1'b1;
        wait_cyc(10);
        send_frame(8'h1D, 1'b0, 1'b0, 4, HALF);
        send_frame(8'h75, 1'b0, 1'b0, 9, HALF);
        ev0 = (got_q.size() > g0)     ? got_q[g0]     : '1;
        ev1 = (got_q.size() > g0 + 1) ? got_q[g0 + 1] : '1;
        n_total++;
        if (got_q.size() - g0 !== 2) $display("FAIL glitch_count got=%0d exp=2", got_q.size() - g0);
        else n_pass++;
        n_total++;
        if (ev0 !== {8'h1D, 2'b00}) $display("FAIL glitch_first got=%h exp=%h", ev0, {8'h1D, 2'b00});
        else n_pass++;
        n_total++;
        if (ev1 !== {8'h75, 2'b00}) $display("FAIL glitch_second got=%h exp=%h", ev1, {8'h75, 2'b00});
        else n_pass++;
        n_total++;
        if (err_cnt - e0 !== 0) $display("FAIL glitch_err got=%0d exp=0", err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int g0, e0;
        ev_t ev;
        do_reset();
        send_frame(8'h1D, 1'b0, 1'b0, -1, HALF);
        n_total++;
        if (ps2.scan_code !== 8'h1D) $display("FAIL rstmid_pre got=%h exp=1d", ps2.scan_code);
        else n_pass++;
        send_bits({2'b11, 8'h5A, 1'b0}, 4, HALF, -1);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({ps2.scan_code, ps2.code_valid, ps2.is_break, ps2.is_extended, ps2.frame_err} !== 12'h000)
            $display("FAIL rstmid_zero got=%h exp=000",
                     {ps2.scan_code, ps2.code_valid, ps2.is_break, ps2.is_extended, ps2.frame_err});
        else n_pass++;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(20);
        g0 = got_q.size(); e0 = err_cnt;
        send_frame(8'h29, 1'b0, 1'b0, -1, HALF);
        ev = (got_q.size() > g0) ? got_q[g0] : '1;
        n_total++;
        if (got_q.size() - g0 !== 1 || ev !== {8'h29, 2'b00})
            $display("FAIL rstmid_next got=%h n=%0d exp=%h n=1", ev, got_q.size() - g0, {8'h29, 2'b00});
        else n_pass++;
        n_total++;
        if (err_cnt - e0 !== 0) $display("FAIL rstmid_err got=%0d exp=0", err_cnt - e0);
        else n_pass++;
    endtask

    task automatic test_typematic();
        int g0, n;
        ev_t first, last;
`ifdef PS2_TYPEMATIC_FILTER_EN
        int exp_n = 2;
`else
        int exp_n = 4;
`endif
        do_reset();
        g0 = got_q.size();
        send_frame(8'h23, 1'b0, 1'b0, -1, HALF);
        send_frame(8'h23, 1'b0, 1'b0, -1, HALF);
        send_frame(8'h23, 1'b0, 1'b0, -1, HALF);
        send_frame(8'hF0, 1'b0, 1'b0, -1, HALF);
        send_frame(8'h23, 1'b0, 1'b0, -1, HALF);
        n     = got_q.size() - g0;
        first = (n > 0) ? got_q[g0] : '1;
        last  = (n > 0) ? got_q[got_q.size() - 1] : '1;
        n_total++;
        if (n !== exp_n) $display("FAIL typematic_count got=%0d exp=%0d", n, exp_n);
        else n_pass++;
        n_total++;
        if (first !== {8'h23, 2'b00}) $display("FAIL typematic_make got=%h exp=%h", first, {8'h23, 2'b00});
        else n_pass++;
        n_total++;
        if (last !== {8'h23, 2'b10}) $display("FAIL typematic_break got=%h exp=%h", last, {8'h23, 2'b10});
        else n_pass++;
    endtask

    task automatic test_random();
        int g0, e0, b0, n_got;
        ev_t ev;
        do_reset();
        g0 = got_q.size(); e0 = err_cnt; b0 = mon_bad;
        exp_q.delete();
        exp_err = 0; m_ext = 1'b0; m_brk = 1'b0; m_held_v = 1'b0; m_held = '0;
        for (int n = 0; n < 30; n++) begin
            int r, half, g;
            logic [7:0] b;
            bit bp, bs;
            r    = $urandom_range(0, 99);
            half = $urandom_range(20, 40);
            g    = -1;
            bp   = 1'b0;
            bs   = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                g    = $urandom_range(0, 10);
                half = $urandom_range(30, 40);
            end
            if (r < 15)      b = 8'hE0;
            else if (r < 32) b = 8'hF0;
            else if (r < 40) b = 8'($urandom_range(0, 255));
            else             b = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) bp = 1'b1;
                else                           bs = 1'b1;
            end
            send_frame(b, bp, bs, g, half);
            model_frame(b, !(bp || bs));
        end
        n_got = got_q.size() - g0;
        n_total++;
        if (n_got !== exp_q.size()) $display("FAIL random_count got=%0d exp=%0d", n_got, exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            ev = (i < n_got) ? got_q[g0 + i] : '1;
            n_total++;
            if (ev !== exp_q[i]) $display("FAIL random_event[%0d] got=%h exp=%h", i, ev, exp_q[i]);
            else n_pass++;
        end
        n_total++;
        if (err_cnt - e0 !== exp_err) $display("FAIL random_frame_err got=%0d exp=%0d", err_cnt - e0, exp_err);
        else n_pass++;
        n_total++;
        if (mon_bad - b0 !== 0) $display("FAIL random_strobe_shape got=%0d exp=0", mon_bad - b0);
        else n_pass++;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_prefix();
        test_frame_errors();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        test_typematic();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
